// File: rtl/aln_pkg.sv
// Shared alignment constants: traceback relative-position codes, geometry defaults
// and the traceback-memory writer state encoding.
package aln_pkg;

  localparam int TBW_B     = 4;
  localparam int TBW_L     = 8;
  localparam int TBW_DEPTH = 2 * TBW_L - TBW_B;

  localparam logic [2:0] REL_NULL    = 3'b111;
  localparam logic [2:0] REL_GAP_R_L = 3'b001;
  localparam logic [2:0] REL_GAP_Q_U = 3'b010;
  localparam logic [2:0] REL_DIAG_L  = 3'b011;
  localparam logic [2:0] REL_DIAG    = 3'b100;
  localparam logic [2:0] REL_GAP_R   = 3'b101;
  localparam logic [2:0] REL_GAP_Q   = 3'b110;

  localparam logic [2:0] BASE_GAP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_TRACE
  } tbw_state_t;

endpackage

// File: rtl/tb_mem_writer_if.sv
// Write-beat handshake from the scoring array plus the traceback read port.
interface tb_mem_writer_if #(
  parameter int B = aln_pkg::TBW_B
);
  logic           in_valid;
  logic           in_ready;
  logic [B-1:0]   in_pe_mask;
  logic [3*B-1:0] in_rel_pos;
  logic [1:0]     rd_pe;
  logic [7:0]     rd_addr;
  logic [7:0]     rd_rel_pos;

  modport master (
    output in_valid, in_pe_mask, in_rel_pos, rd_pe, rd_addr,
    input  in_ready, rd_rel_pos
  );

  modport slave (
    input  in_valid, in_pe_mask, in_rel_pos, rd_pe, rd_addr,
    output in_ready, rd_rel_pos
  );
endinterface

// File: rtl/tb_bank.sv
// One traceback bank: DEPTH x 3-bit flops, single-cycle parallel clear,
// one write port and an asynchronous read port.
module tb_bank
  import aln_pkg::*;
#(
  parameter int DEPTH = TBW_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata
);

  logic [2:0] mem [DEPTH];

  // NOTE: this array is reset like ordinary state because every entry must read
  // back as null after reset; the parallel clear precludes a RAM macro anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= REL_NULL;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= REL_NULL;
    end else if (we) begin
      // A zero code carries no direction, so it is folded into null.
      mem[waddr] <= (wdata == 3'b000) ? REL_NULL : wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : REL_NULL;

endmodule

// File: rtl/tb_mem_writer.sv
// Traceback-memory writer: clears, fills one address per beat across B banks,
// then holds the matrix for zero-latency traceback reads until finish.
module tb_mem_writer
  import aln_pkg::*;
#(
  parameter int B = TBW_B,
  parameter int L = TBW_L
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tb_finish,
  tb_mem_writer_if.slave   bus,
  output logic             start_traceback,
  output logic             busy
);

  localparam int DEPTH = 2 * L - B;
  localparam int AW    = $clog2(DEPTH);

  tbw_state_t    state, state_next;
  logic [AW-1:0] wr_ptr;
  logic          clr;
  logic          fire;
  logic [2:0]    bank_rd [B];
  logic [2:0]    rd_code;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    bus.in_ready = 1'b0;
    clr         = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: begin
        clr        = 1'b1;
        state_next = ST_FILL;
      end
      ST_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && wr_ptr == AW'(DEPTH - 1)) state_next = ST_TRACE;
      end
      ST_TRACE: if (tb_finish) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign fire            = bus.in_valid && bus.in_ready;
  assign start_traceback = (state == ST_TRACE);
  assign busy            = (state != ST_IDLE);

  // FILL leaves on the DEPTH-1 transfer, so the pointer never needs to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    wr_ptr <= '0;
    else if (clr)  wr_ptr <= '0;
    else if (fire) wr_ptr <= wr_ptr + AW'(1);
  end

  for (genvar p = 0; p < B; p++) begin : g_bank
    tb_bank #(.DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (fire && bus.in_pe_mask[p]),
      .waddr (wr_ptr),
      .wdata (bus.in_rel_pos[3*p +: 3]),
      .raddr (bus.rd_addr[AW-1:0]),
      .rdata (bank_rd[p])
    );
  end

  // Out-of-range selects return null, which makes the traceback unit exit.
  always_comb begin
    rd_code = REL_NULL;
    if (int'(bus.rd_pe) < B && int'(bus.rd_addr) < DEPTH) rd_code = bank_rd[bus.rd_pe];
  end

  assign bus.rd_rel_pos = {5'b0, rd_code};

endmodule

// File: tb/tb_tb_mem_writer.sv
// Scoreboard bench for tb_mem_writer: stimulus queues expectations, a negedge
// monitor pops and compares read data, status and traceback start timing.
module tb_tb_mem_writer;
  import aln_pkg::*;

  typedef struct packed {
    logic [7:0] rd;
    logic [2:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tb_finish = 1'b0;
  logic start_traceback;
  logic busy;

  tb_mem_writer_if #(.B(4)) bus ();

  tb_mem_writer #(.B(4), .L(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .tb_finish       (tb_finish),
    .bus             (bus),
    .start_traceback (start_traceback),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    trace_q[$];
  logic  chk_req   = 1'b0;
  logic  final_chk = 1'b0;
  logic  st_prev   = 1'b0;
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0, xfer_cnt = 0, last_xfer = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    int    t;
    cyc++;
    if (!busy) xfer_cnt = 0;
    if (start_traceback && !st_prev) begin
      if (trace_q.size() == 0) check("unexpected_trace", 1, 0);
      else begin
        t = trace_q.pop_front();
        check("trace_xfers", xfer_cnt, t);
        check("trace_latency", cyc - last_xfer, 1);
      end
    end
    st_prev = start_traceback;
    if (bus.in_valid && bus.in_ready) begin
      xfer_cnt++;
      last_xfer = cyc;
    end
    if (chk_req) begin
      if (exp_q.size() == 0) check("orphan_check", 1, 0);
      else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_rd"}, bus.rd_rel_pos, e.rd);
        check({n, "_st"}, {bus.in_ready, start_traceback, busy}, e.st);
      end
    end
    if (final_chk) begin
      check("exp_q_empty", exp_q.size(), 0);
      check("trace_q_empty", trace_q.size(), 0);
    end
  end

  // st = {in_ready, start_traceback, busy}
  task automatic do_check(string n, logic [1:0] pe, logic [7:0] addr,
                          logic [7:0] rd, logic [2:0] st);
    bus.rd_pe   = pe;
    bus.rd_addr = addr;
    chk_req     = 1'b1;
    exp_q.push_back('{rd: rd, st: st});
    name_q.push_back(n);
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic beat(logic [3:0] mask, logic [11:0] codes);
    bus.in_valid   = 1'b1;
    bus.in_pe_mask = mask;
    bus.in_rel_pos = codes;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_pe_mask = '0;
    bus.in_rel_pos = '0;
    bus.rd_pe      = '0;
    bus.rd_addr    = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    do_check("rst_p0a0", 2'd0, 8'd0, 8'h07, 3'b000);
    do_check("rst_p3a11", 2'd3, 8'd11, 8'h07, 3'b000);

    // Full fill with DIAG codes
    trace_q.push_back(12);
    pulse_start();
    do_check("clear_st", 2'd0, 8'd0, 8'h07, 3'b001);
    repeat (12) beat(4'hF, {4{3'b100}});
    do_check("full_p3a11", 2'd3, 8'd11, 8'h04, 3'b011);
    do_check("full_p0a0", 2'd0, 8'd0, 8'h04, 3'b011);
    do_check("oor_addr12", 2'd3, 8'd12, 8'h07, 3'b011);
    tb_finish = 1'b1;
    @(posedge clk); #1;
    tb_finish = 1'b0;
    do_check("idle_keep", 2'd2, 8'd5, 8'h04, 3'b000);

    // Restart: partial mask, zero mask, busy start, stall, ignored finish
    trace_q.push_back(12);
    pulse_start();
    do_check("clear_old", 2'd0, 8'd0, 8'h04, 3'b001);
    do_check("fill_wiped", 2'd0, 8'd0, 8'h07, 3'b101);
    beat(4'b0101, {4{3'b011}});
    do_check("pm_p0a0", 2'd0, 8'd0, 8'h03, 3'b101);
    do_check("pm_p1a0", 2'd1, 8'd0, 8'h07, 3'b101);
    do_check("pm_p2a0", 2'd2, 8'd0, 8'h03, 3'b101);
    do_check("pm_p3a0", 2'd3, 8'd0, 8'h07, 3'b101);
    beat(4'b0000, {4{3'b101}});
    start = 1'b1;
    beat(4'hF, {3'b110, 3'b000, 3'b010, 3'b001});
    start = 1'b0;
    bus.in_pe_mask = 4'hF;
    bus.in_rel_pos = {4{3'b001}};
    tb_finish = 1'b1;
    repeat (5) @(posedge clk);
    #1 tb_finish = 1'b0;
    do_check("stall_p0a3", 2'd0, 8'd3, 8'h07, 3'b101);
    for (int i = 3; i < 11; i++) beat(4'hF, {4{3'b101}});
    beat(4'hF, {3'b110, 3'b101, 3'b100, 3'b011});
    do_check("zm_p0a1", 2'd0, 8'd1, 8'h07, 3'b011);
    do_check("zero_p2a2", 2'd2, 8'd2, 8'h07, 3'b011);
    do_check("mix_p3a2", 2'd3, 8'd2, 8'h06, 3'b011);
    do_check("mix_p1a2", 2'd1, 8'd2, 8'h02, 3'b011);
    do_check("mix_p0a2", 2'd0, 8'd2, 8'h01, 3'b011);
    do_check("resume_p1a3", 2'd1, 8'd3, 8'h05, 3'b011);
    do_check("last_p0a11", 2'd0, 8'd11, 8'h03, 3'b011);
    do_check("last_p3a11", 2'd3, 8'd11, 8'h06, 3'b011);
    do_check("mid_p2a10", 2'd2, 8'd10, 8'h05, 3'b011);
    do_check("oor_addr255", 2'd1, 8'd255, 8'h07, 3'b011);

    // start and tb_finish together in TRACE: finish wins, start dropped
    start = 1'b1;
    tb_finish = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tb_finish = 1'b0;
    do_check("fin_start_idle", 2'd1, 8'd3, 8'h05, 3'b000);
    do_check("still_idle", 2'd0, 8'd0, 8'h03, 3'b000);

    // Reset in the middle of FILL
    pulse_start();
    do_check("clear3", 2'd0, 8'd0, 8'h03, 3'b001);
    repeat (6) beat(4'hF, {4{3'b100}});
    do_check("mid_p0a5", 2'd0, 8'd5, 8'h04, 3'b101);
    rst_n = 1'b0;
    do_check("rst_mid_p0a5", 2'd0, 8'd5, 8'h07, 3'b000);
    rst_n = 1'b1;
    do_check("rst_oor12", 2'd0, 8'd12, 8'h07, 3'b000);
    do_check("rst_p3a0", 2'd3, 8'd0, 8'h07, 3'b000);

    final_chk = 1'b1;
    @(negedge clk); #1;
    final_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
